// File: rtl/frame_arbiter_if.sv
// Source-FIFO, padder and output-monitor signals of the frame arbiter.
// The master modport is the arbiter's view; slave is the surrounding datapath.
interface frame_arbiter_if #(
  parameter int DWIDTH = 8
);
  logic              req0_rd_en;
  logic [DWIDTH-1:0] req0_dout;
  logic              req0_empty;
  logic              req1_rd_en;
  logic [DWIDTH-1:0] req1_dout;
  logic              req1_empty;
  logic              pad_rd_en;
  logic [DWIDTH-1:0] pad_dout;
  logic              pad_empty;
  logic              out_wr_en;
  logic              done_valid;
  logic              done_id;
  logic              busy;
  logic              err_orphan;

  modport master (
    output req0_rd_en, req1_rd_en, pad_dout, pad_empty,
           done_valid, done_id, busy, err_orphan,
    input  req0_dout, req0_empty, req1_dout, req1_empty,
           pad_rd_en, out_wr_en
  );

  modport slave (
    input  req0_rd_en, req1_rd_en, pad_dout, pad_empty,
           done_valid, done_id, busy, err_orphan,
    output req0_dout, req0_empty, req1_dout, req1_empty,
           pad_rd_en, out_wr_en
  );
endinterface

// File: rtl/frame_arbiter.sv
// Frame-granular round-robin arbiter feeding one padder from two pixel FIFOs,
// tagging each completed output frame with the source it was granted from.
module frame_arbiter #(
  parameter int DWIDTH     = 8,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int ID_DEPTH   = 4
) (
  input  logic           clock,
  input  logic           reset,
  frame_arbiter_if.master bus
);

  localparam int unsigned FRAME_PX = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [23:0] LAST_PX  = 24'(FRAME_PX - 1);
  localparam int          PTR_W    = $clog2(ID_DEPTH);
  localparam int          CNT_W    = PTR_W + 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [23:0]       in_cnt_q, in_cnt_d;
  logic [23:0]       out_cnt_q;
  logic              done_valid_q, done_id_q, err_orphan_q;

  logic [ID_DEPTH-1:0] id_mem;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    id_cnt_q;

  logic              push, pop, q_full, q_empty;
  logic              accept, src_empty, other, other_empty;
  logic [DWIDTH-1:0] src_dout;

  assign q_full  = (id_cnt_q == CNT_W'(ID_DEPTH));
  assign q_empty = (id_cnt_q == '0);

  assign src_empty   = grant_q ? bus.req1_empty : bus.req0_empty;
  assign src_dout    = grant_q ? bus.req1_dout  : bus.req0_dout;
  assign other       = ~last_grant_q;
  assign other_empty = other ? bus.req1_empty : bus.req0_empty;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    in_cnt_d     = in_cnt_q;
    push         = 1'b0;
    accept       = 1'b0;
    bus.pad_empty = 1'b1;
    bus.pad_dout  = bus.req0_dout;
    unique case (state_q)
      IDLE: begin
        if (!q_full && (!bus.req0_empty || !bus.req1_empty)) begin
          grant_d  = other_empty ? last_grant_q : other;
          push     = 1'b1;
          in_cnt_d = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        bus.pad_empty = src_empty;
        bus.pad_dout  = src_dout;
        accept        = bus.pad_rd_en & ~src_empty;
        if (accept) begin
          if (in_cnt_q == LAST_PX) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
            in_cnt_d     = '0;
          end else begin
            in_cnt_d = in_cnt_q + 24'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req0_rd_en = accept & ~grant_q;
  assign bus.req1_rd_en = accept &  grant_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      in_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      in_cnt_q     <= in_cnt_d;
    end
  end

  // Output side tracks padder writes independently of the input state.
  assign pop = bus.out_wr_en & ~q_empty & (out_cnt_q == LAST_PX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_cnt_q    <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= 1'b0;
      err_orphan_q <= 1'b0;
    end else begin
      done_valid_q <= pop;
      if (pop) done_id_q <= id_mem[rd_ptr_q];
      if (bus.out_wr_en) begin
        if (q_empty)  err_orphan_q <= 1'b1;
        else if (pop) out_cnt_q    <= '0;
        else          out_cnt_q    <= out_cnt_q + 24'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      id_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   id_cnt_q <= id_cnt_q + CNT_W'(1);
        2'b01:   id_cnt_q <= id_cnt_q - CNT_W'(1);
        default: id_cnt_q <= id_cnt_q;
      endcase
    end
  end

  // NOTE: ID storage is not reset; an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (push) id_mem[wr_ptr_q] <= grant_d;
  end

  assign bus.done_valid = done_valid_q;
  assign bus.done_id    = done_id_q;
  assign bus.err_orphan = err_orphan_q;
  assign bus.busy       = (state_q == STREAM) || !q_empty;

endmodule

// File: tb/tb_frame_arbiter.sv
// Directed and randomized bench for frame_arbiter against a queue-based
// frame-level model of arbitration, streaming and completion tagging.
module tb_frame_arbiter;

  localparam int W           = 4;
  localparam int H           = 3;
  localparam int FRAME       = W * H;
  localparam int DEPTH       = 2;
  localparam int RAND_CYCLES = 3000;

  logic clock;
  logic reset;

  frame_arbiter_if #(.DWIDTH(8)) bus ();

  frame_arbiter #(
    .DWIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ID_DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Environment: FWFT source FIFOs plus stimulus knobs
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit stall0, stall1, pad_rd, owr;

  // Frame-level model
  bit m_in_frame, m_cur, m_last, m_done, m_done_id, m_err;
  int m_sent, m_outp;
  bit m_ids[$];

  // Per-cycle samples and logs of observed behaviour
  logic       s_pe, s_rd0, s_rd1, s_dv, s_did, s_busy, s_err;
  logic [7:0] s_dout;
  int cyc = 0;
  int dut_px;
  int grant_log[$];
  int start_log[$];
  int end_log[$];
  int done_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic drive_inputs();
    bus.req0_empty = stall0 || (q0.size() == 0);
    bus.req0_dout  = (q0.size() != 0) ? q0[0] : 8'h00;
    bus.req1_empty = stall1 || (q1.size() == 0);
    bus.req1_dout  = (q1.size() != 0) ? q1[0] : 8'h00;
    bus.pad_rd_en  = pad_rd;
    bus.out_wr_en  = owr;
  endtask

  task automatic model_reset();
    m_in_frame = 1'b0; m_cur = 1'b0; m_last = 1'b1;
    m_done = 1'b0; m_done_id = 1'b0; m_err = 1'b0;
    m_sent = 0; m_outp = 0;
    m_ids.delete();
  endtask

  task automatic fill(input int which, input int n, input int base);
    for (int i = 0; i < n; i++) begin
      if (which == 0) q0.push_back(8'(base + i));
      else            q1.push_back(8'(base + i));
    end
  endtask

  // One clock: drive at negedge, compare against the model, advance model and FIFOs.
  task automatic cycle();
    bit e0, e1, cur_empty, exp_pe, exp_r0, exp_r1, other;
    logic [7:0] h0, h1, exp_d;
    int pre_size;
    @(negedge clock);
    drive_inputs();
    #1;
    e0 = bus.req0_empty; e1 = bus.req1_empty;
    h0 = bus.req0_dout;  h1 = bus.req1_dout;
    exp_pe = 1'b1; exp_r0 = 1'b0; exp_r1 = 1'b0; exp_d = h0;
    if (m_in_frame) begin
      cur_empty = m_cur ? e1 : e0;
      exp_pe = cur_empty;
      exp_d  = m_cur ? h1 : h0;
      exp_r0 = !m_cur && pad_rd && !cur_empty;
      exp_r1 =  m_cur && pad_rd && !cur_empty;
    end
    check("pad_empty", 32'(bus.pad_empty), 32'(exp_pe));
    check("req0_rd_en", 32'(bus.req0_rd_en), 32'(exp_r0));
    check("req1_rd_en", 32'(bus.req1_rd_en), 32'(exp_r1));
    if (!exp_pe) check("pad_dout", 32'(bus.pad_dout), 32'(exp_d));
    check("done_valid", 32'(bus.done_valid), 32'(m_done));
    if (m_done) check("done_id", 32'(bus.done_id), 32'(m_done_id));
    check("busy", 32'(bus.busy), 32'(m_in_frame || (m_ids.size() != 0)));
    check("err_orphan", 32'(bus.err_orphan), 32'(m_err));

    s_pe = bus.pad_empty; s_rd0 = bus.req0_rd_en; s_rd1 = bus.req1_rd_en;
    s_dout = bus.pad_dout; s_dv = bus.done_valid; s_did = bus.done_id;
    s_busy = bus.busy; s_err = bus.err_orphan;
    cyc++;

    if (s_rd0 || s_rd1) begin
      if (dut_px % FRAME == 0) begin
        grant_log.push_back(int'(s_rd1));
        start_log.push_back(cyc);
      end
      if (dut_px % FRAME == FRAME - 1) end_log.push_back(cyc);
      dut_px++;
    end
    if (s_dv) done_log.push_back(int'(s_did));

    // Model advance: queue fullness and emptiness are judged before this cycle's push/pop.
    pre_size = m_ids.size();
    m_done = 1'b0;
    if (owr) begin
      if (pre_size == 0) m_err = 1'b1;
      else begin
        m_outp++;
        if (m_outp == FRAME) begin
          m_outp = 0;
          m_done = 1'b1;
          m_done_id = m_ids.pop_front();
        end
      end
    end
    if (!m_in_frame) begin
      if (pre_size < DEPTH && (!e0 || !e1)) begin
        other = !m_last;
        m_cur = ((other ? e1 : e0) == 1'b0) ? other : m_last;
        m_ids.push_back(m_cur);
        m_in_frame = 1'b1;
        m_sent = 0;
      end
    end else if (pad_rd && !(m_cur ? e1 : e0)) begin
      m_sent++;
      if (m_sent == FRAME) begin
        m_in_frame = 1'b0;
        m_last = m_cur;
      end
    end

    @(posedge clock);
    if (s_rd0 && q0.size() != 0) void'(q0.pop_front());
    if (s_rd1 && q1.size() != 0) void'(q1.pop_front());
  endtask

  task automatic apply_reset();
    @(negedge clock);
    drive_inputs();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_pad_empty", 32'(bus.pad_empty), 32'd1);
    check("rst_req0_rd_en", 32'(bus.req0_rd_en), 32'd0);
    check("rst_req1_rd_en", 32'(bus.req1_rd_en), 32'd0);
    check("rst_done_valid", 32'(bus.done_valid), 32'd0);
    check("rst_done_id", 32'(bus.done_id), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err_orphan", 32'(bus.err_orphan), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    dut_px = 0;
    grant_log.delete(); start_log.delete(); end_log.delete(); done_log.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0, st, nrd, last_rd, first_w, last_w;
    bit rd1_seen;
    reset = 1'b1;
    stall0 = 0; stall1 = 0; pad_rd = 1; owr = 0;
    drive_inputs();

    // 1: single source-0 frame, then its completion
    q0.delete(); q1.delete();
    apply_reset();
    fill(0, 12, 1);
    for (int i = 0; i < 14; i++) begin
      cycle();
      check("t1_rd1", 32'(s_rd1), 32'd0);
      if (i == 0 || i == 13) check("t1_rd0_idle", 32'(s_rd0), 32'd0);
      else begin
        check("t1_rd0", 32'(s_rd0), 32'd1);
        check("t1_dout", 32'(s_dout), 32'(i));
      end
    end
    owr = 1;
    repeat (12) cycle();
    owr = 0;
    cycle();
    check("t1_done_valid", 32'(s_dv), 32'd1);
    check("t1_done_id", 32'(s_did), 32'd0);
    cycle();
    check("t1_done_pulse", 32'(s_dv), 32'd0);
    check("t1_busy", 32'(s_busy), 32'd0);

    // 2: both sources busy, output keeps up
    q0.delete(); q1.delete();
    apply_reset();
    fill(0, 60, 0); fill(1, 60, 128);
    for (int i = 0; i < 70; i++) begin
      owr = (m_ids.size() != 0);
      cycle();
    end
    owr = 0;
    check("t2_frames", 32'(grant_log.size() >= 4), 32'd1);
    check("t2_dones", 32'(done_log.size() >= 4), 32'd1);
    if (grant_log.size() >= 4 && end_log.size() >= 3 && done_log.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        check("t2_grant", 32'(grant_log[k]), 32'(k % 2));
        check("t2_done_id", 32'(done_log[k]), 32'(k % 2));
      end
      for (int k = 0; k < 3; k++)
        check("t2_bubble", 32'(start_log[k+1] - end_log[k] - 1), 32'd1);
    end

    // 3: source 0 runs dry mid-frame
    q0.delete(); q1.delete();
    apply_reset();
    fill(0, 12, 1); fill(1, 20, 128);
    n0 = 0; st = 0; rd1_seen = 0;
    for (int i = 0; i < 40 && n0 < 12; i++) begin
      stall0 = (n0 == 5 && st < 3);
      cycle();
      if (stall0) begin
        st++;
        check("t3_stall_pe", 32'(s_pe), 32'd1);
      end
      if (s_rd1) rd1_seen = 1;
      if (s_rd0) begin
        n0++;
        if (n0 == 6)  check("t3_resume", 32'(s_dout), 32'd6);
        if (n0 == 12) check("t3_last", 32'(s_dout), 32'd12);
      end
    end
    stall0 = 0;
    check("t3_reads", 32'(n0), 32'd12);
    check("t3_stalls", 32'(st), 32'd3);
    check("t3_no_rd1", 32'(rd1_seen), 32'd0);

    // 4: ID queue fills, completion frees a slot two cycles later
    q0.delete(); q1.delete();
    apply_reset();
    fill(0, 40, 0); fill(1, 40, 128);
    nrd = 0; last_rd = -1;
    for (int i = 0; i < 45; i++) begin
      cycle();
      if (s_rd0 || s_rd1) begin nrd++; last_rd = i; end
    end
    check("t4_reads", 32'(nrd), 32'd24);
    check("t4_quiet", 32'(last_rd < 35), 32'd1);
    check("t4_busy", 32'(s_busy), 32'd1);
    owr = 1;
    repeat (12) cycle();
    owr = 0;
    cycle();
    check("t4_done_valid", 32'(s_dv), 32'd1);
    check("t4_done_id", 32'(s_did), 32'd0);
    check("t4_no_grant_yet", 32'(s_pe), 32'd1);
    cycle();
    check("t4_regrant_pe", 32'(s_pe), 32'd0);
    check("t4_regrant_src0", 32'(s_rd0), 32'd1);

    // 5: orphan output writes
    q0.delete(); q1.delete();
    apply_reset();
    owr = 1;
    repeat (3) cycle();
    owr = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t5_err", 32'(s_err), 32'd1);
      check("t5_done_valid", 32'(s_dv), 32'd0);
      check("t5_busy", 32'(s_busy), 32'd0);
    end
    apply_reset();
    cycle();
    check("t5_err_cleared", 32'(s_err), 32'd0);

    // 6: reset during word 6, frame restarts with fresh reads
    q0.delete(); q1.delete();
    apply_reset();
    fill(0, 24, 1);
    n0 = 0;
    for (int i = 0; i < 20 && n0 < 5; i++) begin
      cycle();
      if (s_rd0) n0++;
    end
    check("t6_pre_reads", 32'(n0), 32'd5);
    apply_reset();
    n0 = 0; first_w = -1; last_w = -1;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (s_rd0) begin
        if (n0 == 0) first_w = int'(s_dout);
        n0++;
        if (n0 == 12) last_w = int'(s_dout);
      end
    end
    check("t6_reads", 32'(n0), 32'd12);
    check("t6_first_word", 32'(first_w), 32'd6);
    check("t6_last_word", 32'(last_w), 32'd17);

    // Randomized traffic against the model
    q0.delete(); q1.delete();
    apply_reset();
    for (int i = 0; i < RAND_CYCLES; i++) begin
      if (q0.size() < 4 && $urandom_range(0, 3) == 0) fill(0, 8, $urandom_range(0, 255));
      if (q1.size() < 4 && $urandom_range(0, 3) == 0) fill(1, 8, $urandom_range(0, 255));
      stall0 = ($urandom_range(0, 7) == 0);
      stall1 = ($urandom_range(0, 7) == 0);
      pad_rd = ($urandom_range(0, 3) != 0);
      owr = ($urandom_range(0, 2) != 0) && ((m_ids.size() != 0) || ($urandom_range(0, 199) == 0));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
